// File: rtl/pkt_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : pkt_uart_tx
// Description : Packet UART transmitter. Sends MSG_BYTES payload bytes
//               (highest index first) followed by their CRC-16/CCITT-FALSE.
//               Optional even parity per frame when TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_uart_tx #(
    parameter int          MSG_BYTES    = 16,
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [15:0] CRC_INIT     = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MSG_BYTES*8-1:0] msg_in,
    output logic                   tx_out,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            crc_out
);

    localparam logic [15:0] c_last_cnt   = 16'(CLKS_PER_BIT - 1);
    localparam logic [6:0]  c_last_byte  = 7'(MSG_BYTES - 1);
    localparam logic [1:0]  c_ph_payload = 2'd0;
    localparam logic [1:0]  c_ph_crc_hi  = 2'd1;
    localparam logic [1:0]  c_ph_crc_lo  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
`ifdef TX_PARITY_EN
        S_PAR   = 3'd3,
`endif
        S_STOP  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   w_wrap;
    logic [15:0]            r_bit_cnt;
    logic [2:0]             r_bit_idx;
    logic [6:0]             r_byte_idx;
    logic [1:0]             r_phase;
    logic [MSG_BYTES*8-1:0] r_msg;
    logic [7:0]             r_shift;
    logic [15:0]            r_crc;
    logic [15:0]            r_crc_out;
    logic                   r_tx;

    // One CRC-16/CCITT-FALSE step over a whole byte, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign w_wrap  = (r_bit_cnt == c_last_cnt);
    assign tx_out  = r_tx;
    assign crc_out = r_crc_out;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                busy = 1'b1;
                if (w_wrap) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                busy = 1'b1;
`ifdef TX_PARITY_EN
                if (w_wrap && r_bit_idx == 3'd7) w_state_nxt = S_PAR;
`else
                if (w_wrap && r_bit_idx == 3'd7) w_state_nxt = S_STOP;
`endif
            end
`ifdef TX_PARITY_EN
            S_PAR: begin
                busy = 1'b1;
                if (w_wrap) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                busy = 1'b1;
                if (w_wrap) w_state_nxt = (r_phase == c_ph_crc_lo) ? S_FIN : S_START;
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_phase    <= c_ph_payload;
            r_msg      <= '0;
            r_shift    <= '0;
            r_crc      <= '0;
            r_crc_out  <= '0;
            r_tx       <= 1'b1;
        end else begin
            if (r_state == S_IDLE || r_state == S_FIN || w_wrap) r_bit_cnt <= '0;
            else                                                 r_bit_cnt <= r_bit_cnt + 16'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // The top byte goes straight into the shifter; the rest queue up in r_msg.
                        r_msg      <= msg_in << 8;
                        r_shift    <= msg_in[MSG_BYTES*8-1 -: 8];
                        r_crc      <= crc16_byte(CRC_INIT, msg_in[MSG_BYTES*8-1 -: 8]);
                        r_byte_idx <= c_last_byte;
                        r_phase    <= c_ph_payload;
                        r_tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_wrap) begin
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_wrap) begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
`ifdef TX_PARITY_EN
                            r_tx      <= ^r_shift;
`else
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[r_bit_idx + 3'd1];
                        end
                    end
                end
`ifdef TX_PARITY_EN
                S_PAR: begin
                    if (w_wrap) r_tx <= 1'b1;
                end
`endif
                S_STOP: begin
                    if (w_wrap) begin
                        case (r_phase)
                            c_ph_payload: begin
                                r_tx <= 1'b0;
                                if (r_byte_idx == 7'd0) begin
                                    r_shift <= r_crc[15:8];
                                    r_phase <= c_ph_crc_hi;
                                end else begin
                                    r_byte_idx <= r_byte_idx - 7'd1;
                                    r_shift    <= r_msg[MSG_BYTES*8-1 -: 8];
                                    r_msg      <= r_msg << 8;
                                    r_crc      <= crc16_byte(r_crc, r_msg[MSG_BYTES*8-1 -: 8]);
                                end
                            end
                            c_ph_crc_hi: begin
                                r_tx    <= 1'b0;
                                r_shift <= r_crc[7:0];
                                r_phase <= c_ph_crc_lo;
                            end
                            default: begin
                                r_tx      <= 1'b1;
                                r_crc_out <= r_crc;
                            end
                        endcase
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_uart_tx
// Description : Directed/random bench for pkt_uart_tx using a bit-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_uart_tx;

    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [71:0] msg = '0;

    logic        start_a, tx_a, busy_a, done_a;
    logic        start_b, tx_b, busy_b, done_b;
    logic [15:0] crc_a, crc_b;
    logic        tx, busy, done;
    logic [15:0] crc;

    int          n_asserts = 0;
    int          n_fail = 0;
    bit          exp_bits[$];
    logic [15:0] last_crc;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign tx      = sel ? tx_b   : tx_a;
    assign busy    = sel ? busy_b : busy_a;
    assign done    = sel ? done_b : done_a;
    assign crc     = sel ? crc_b  : crc_a;

    pkt_uart_tx #(.MSG_BYTES(1), .CLKS_PER_BIT(CPB), .CRC_INIT(16'hFFFF)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .msg_in(msg[7:0]),
        .tx_out(tx_a), .busy(busy_a), .done(done_a), .crc_out(crc_a)
    );

    pkt_uart_tx #(.MSG_BYTES(9), .CLKS_PER_BIT(CPB), .CRC_INIT(16'hFFFF)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .msg_in(msg),
        .tx_out(tx_b), .busy(busy_b), .done(done_b), .crc_out(crc_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC-16/CCITT-FALSE over the message bit stream, highest byte first.
    function automatic logic [15:0] model_crc(input logic [71:0] m, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = n - 1; k >= 0; k--) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ m[8*k+b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef TX_PARITY_EN
        exp_bits.push_back(^b);
`endif
        exp_bits.push_back(1'b1);
    endtask

    // Entered and left just after a rising edge. Cycle 0 holds start high;
    // cycle t is the t-th cycle after the accepting edge.
    task automatic run_packet(input logic s, input logic [71:0] m, input int hold,
                              input int pulse_at, input bit fin_pulse, input int abort_at);
        int          n;
        int          t_end;
        logic [15:0] ec;
        n  = s ? 9 : 1;
        ec = model_crc(m, n);
        exp_bits.delete();
        for (int k = n - 1; k >= 0; k--) push_frame(m[8*k +: 8]);
        push_frame(ec[15:8]);
        push_frame(ec[7:0]);
        t_end = (n + 2) * FB * CPB;
        sel   = s;
        msg   = m;
        start = 1'b1;
        for (int t = 1; t <= t_end + 4; t++) begin
            @(posedge clk); #1;
            if (abort_at > 0 && t > abort_at) begin
                chk("abort_line", {29'd0, tx, busy, done}, {29'd0, 3'b100});
                chk("abort_crc", {16'd0, crc}, 32'd0);
                reset = 1'b0;
                break;
            end
            if (t <= t_end) begin
                chk("frame_bits", {29'd0, tx, busy, done}, {29'd0, exp_bits[(t-1)/CPB], 2'b10});
            end else if (t == t_end + 1) begin
                chk("done_pulse", {29'd0, tx, busy, done}, {29'd0, 3'b101});
                chk("crc_at_done", {16'd0, crc}, {16'd0, ec});
                last_crc = crc;
            end else begin
                chk("idle_after", {13'd0, tx, busy, done, crc}, {13'd0, 3'b100, ec});
            end
            if (t == 1) msg = {8'($urandom), 32'($urandom), 32'($urandom)};
            start = (t < hold) || (t == pulse_at) || (fin_pulse && t == t_end + 1);
            if (abort_at > 0 && t == abort_at) reset = 1'b1;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [71:0] m;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            chk("reset_idle_a", {13'd0, tx_a, busy_a, done_a, crc_a}, {13'd0, 3'b100, 16'h0000});
            chk("reset_idle_b", {13'd0, tx_b, busy_b, done_b, crc_b}, {13'd0, 3'b100, 16'h0000});
        end

        run_packet(1'b0, 72'h00, 1, 0, 1'b0, 0);
        chk("crc_single_zero", {16'd0, last_crc}, {16'd0, 16'hE1F0});

        run_packet(1'b1, "123456789", 1, 0, 1'b0, 0);
        chk("crc_check_string", {16'd0, last_crc}, {16'd0, 16'h29B1});

        m = {8'($urandom), 32'($urandom), 32'($urandom)};
        run_packet(1'b1, m, 3, 200, 1'b1, 0);

        m = {8'($urandom), 32'($urandom), 32'($urandom)};
        run_packet(1'b1, m, 1, 0, 1'b0, 1 + (2 * FB + 4) * CPB + 1);
        for (int i = 0; i < 2 * FB * CPB; i++) begin
            @(posedge clk); #1;
            chk("post_abort_quiet", {29'd0, tx, busy, done}, {29'd0, 3'b100});
        end
        m = {8'($urandom), 32'($urandom), 32'($urandom)};
        run_packet(1'b1, m, 1, 0, 1'b0, 0);

        run_packet(1'b0, 72'h07, 1, 0, 1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            m = {8'($urandom), 32'($urandom), 32'($urandom)};
            run_packet(r[0], m, int'($urandom_range(1, 3)), int'($urandom_range(5, 100)), r[1], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_uart_tx.md
PKT_UART_TX -- requirements
Module: pkt_uart_tx

Interface
REQ-001 Parameter MSG_BYTES, default 16: payload bytes per packet; legal range 1..64.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 2..65535.
REQ-003 Parameter CRC_INIT, default 16'hFFFF: CRC register value at packet start.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  packet request; sampled only in IDLE.
REQ-007 msg_in  input  MSG_BYTES*8  payload; byte k = msg_in[8k+7:8k].
REQ-008 tx_out  output  1  UART serial line, idle high.
REQ-009 busy  output  1  high from the cycle after accepted start until done.
REQ-010 done  output  1  one-cycle pulse at packet end.
REQ-011 crc_out  output  16  CRC of last packet; valid from done onward.

Function
REQ-012 The FSM SHALL use states IDLE, START, DATA, PAR (present only with TX_PARITY_EN), STOP, FIN.
REQ-013 In IDLE with start=1, msg_in SHALL be latched, the CRC register set to CRC_INIT, the byte index set to MSG_BYTES-1, and the FSM SHALL enter START on the next edge.
REQ-014 start while busy=1 SHALL be ignored; msg_in changes after acceptance SHALL have no effect.
REQ-015 Payload bytes SHALL be sent highest index first (byte MSG_BYTES-1 first, byte 0 last), followed by CRC[15:8], then CRC[7:0].
REQ-016 Each frame: one start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1); every bit held exactly CLKS_PER_BIT cycles.
REQ-017 tx_out SHALL be registered; the first start bit SHALL appear the cycle after start is sampled.
REQ-018 Frames SHALL be back-to-back: the next start bit follows the previous stop bit with no idle gap.
REQ-019 CRC SHALL be CRC-16/CCITT-FALSE (poly 16'h1021, MSB-first, no reflection, no final XOR), updated over a whole payload byte in the cycle that byte is loaded into the shift register.
REQ-020 CRC bytes SHALL NOT be included in the CRC computation.
REQ-021 After the stop bit of the second CRC byte, the FSM SHALL enter FIN for one cycle: done=1, busy=0, then return to IDLE.
REQ-022 start sampled in the FIN cycle SHALL be ignored; a new packet can be accepted from the following IDLE cycle.
REQ-023 Packet duration, start sample to done, SHALL be (MSG_BYTES+2)*FRAME_BITS*CLKS_PER_BIT+1 cycles, FRAME_BITS=10 (11 with parity).
REQ-024 The bit counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the bit index SHALL count 0..7 within DATA.
REQ-025 crc_out SHALL hold its value until the next accepted start.

Reset
REQ-026 With reset=1 at an edge: FSM=IDLE, tx_out=1, busy=0, done=0, crc_out=16'h0000, all counters 0.
REQ-027 Reset mid-packet SHALL abort immediately; no done pulse and no further frame bits SHALL be produced.
REQ-028 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) SHALL be inserted between data bit 7 and the stop bit, FRAME_BITS=11.
REQ-030 TX_PARITY_EN undefined: no PAR state and no parity logic, FRAME_BITS=10.

Verification
REQ-031 Reset then idle 100 cycles -> tx_out=1, busy=0, done=0, crc_out=0 throughout.
REQ-032 MSG_BYTES=1, CLKS_PER_BIT=4, msg_in=8'h00, pulse start -> frames 00, E1, F0 on tx_out; done 121 cycles after start; crc_out=16'hE1F0.
REQ-033 MSG_BYTES=9, msg_in bytes 8..0 = ASCII "123456789" -> crc_out=16'h29B1; last two frames 29, B1.
REQ-034 Start held high for 3 cycles, plus a pulse mid-packet -> exactly one packet; busy high continuously until done.
REQ-035 Reset asserted during data bit 3 of byte 2 -> tx_out=1 next cycle, busy=0, no done; next start yields a correct full packet.
REQ-036 TX_PARITY_EN, MSG_BYTES=1, msg_in=8'h07 -> parity bit 1; frame 11 bits; done at 3*11*CLKS_PER_BIT+1 cycles.
